mem_arbiter: RTL and testbench

Arbitrates the single memory-controller request port among the instruction fetch unit, the load path and the committed-store path. Each requester holds a request until it receives a done pulse. The arbiter captures the winning request into a one-deep holding register and drives the controller's unified request port. It squashes speculative traffic on rollback and withholds I/O stores while the UART buffer is full.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants for the memory-request arbiter:
//   - request kind encodings carried on mc_kind
//   - the address bits that mark the I/O (UART) region
//   - default fetch line width
//   - helper that classifies an address as I/O
package mem_arbiter_pkg;

    localparam logic [1:0] KIND_FETCH = 2'd0;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    // addr[17:16] equal to this value selects the I/O region
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    localparam int IF_DATA_W = 128;

    function automatic logic is_io_region(input logic [1:0] addr_hi);
        return addr_hi == IO_ADDR_HI;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational priority pick among the three requesters.
//   Inputs : if_req, ld_req, st_req  - pending requests
//            st_io_blocked          - store targets I/O while the UART buffer is full
//            rollback               - flush; fetch and load may not win this cycle
//            starve                 - fetch has lost enough arbitrations to win outright
//   Output : grant[2:0]             - one-hot, bit index equals the request kind
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       ld_req,
    input  logic       st_req,
    input  logic       st_io_blocked,
    input  logic       rollback,
    input  logic       starve,
    output logic [2:0] grant
);

    logic st_ok;
    logic ld_ok;
    logic if_ok;

    assign st_ok = st_req && !st_io_blocked;
    assign ld_ok = ld_req && !rollback;
    assign if_ok = if_req && !rollback;

    always_comb begin
        grant = 3'b000;
        // a starved fetch overrides the normal STORE > LOAD > FETCH order
        if (starve && if_ok) begin
            grant[KIND_FETCH] = 1'b1;
        end else if (st_ok) begin
            grant[KIND_STORE] = 1'b1;
        end else if (ld_ok) begin
            grant[KIND_LOAD] = 1'b1;
        end else if (if_ok) begin
            grant[KIND_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single memory-controller request port between instruction
//   fetch, loads and committed stores. The winning request is captured into a
//   one-deep holding register that drives mc_*. Speculative (fetch/load)
//   traffic is squashed on rollback; I/O stores wait while the UART is full.
//   Ports:
//     clk, rst_n (sync, active-low), rdy (global enable; low freezes all state)
//     rollback, io_buffer_full
//     if_req/if_pc  -> if_done/if_data   fetch
//     ld_req/ld_addr/ld_len -> ld_done/ld_data   load
//     st_req/st_addr/st_len/st_data -> st_done   store
//     mc_req/mc_kind/mc_addr/mc_len/mc_wdata -> controller request
//     mc_done/mc_rdata/mc_ifdata <- controller response
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int IF_DATA_W  = mem_arbiter_pkg::IF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 io_buffer_full,
    input  logic                 if_req,
    input  logic [31:0]          if_pc,
    output logic                 if_done,
    output logic [IF_DATA_W-1:0] if_data,
    input  logic                 ld_req,
    input  logic [31:0]          ld_addr,
    input  logic [2:0]           ld_len,
    output logic                 ld_done,
    output logic [31:0]          ld_data,
    input  logic                 st_req,
    input  logic [31:0]          st_addr,
    input  logic [2:0]           st_len,
    input  logic [31:0]          st_data,
    output logic                 st_done,
    output logic                 mc_req,
    output logic [1:0]           mc_kind,
    output logic [31:0]          mc_addr,
    output logic [2:0]           mc_len,
    output logic [31:0]          mc_wdata,
    input  logic                 mc_done,
    input  logic [31:0]          mc_rdata,
    input  logic [IF_DATA_W-1:0] mc_ifdata
);
    import mem_arbiter_pkg::*;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]           state_q,      state_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 mc_req_q,     mc_req_d;
    logic [1:0]           mc_kind_q,    mc_kind_d;
    logic [31:0]          mc_addr_q,    mc_addr_d;
    logic [2:0]           mc_len_q,     mc_len_d;
    logic [31:0]          mc_wdata_q,   mc_wdata_d;
    logic                 if_done_q,    if_done_d;
    logic                 ld_done_q,    ld_done_d;
    logic                 st_done_q,    st_done_d;
    logic [31:0]          ld_data_q,    ld_data_d;
    logic [IF_DATA_W-1:0] if_data_q,    if_data_d;

    logic [2:0] grant;
    logic       st_io_blocked;
    logic       squash;

    assign st_io_blocked = is_io_region(st_addr[17:16]) && io_buffer_full;
    // stores are never squashed; only the speculative kinds react to rollback
    assign squash        = rollback && (mc_kind_q != KIND_STORE);

    mem_arb_pick u_pick (
        .if_req        (if_req),
        .ld_req        (ld_req),
        .st_req        (st_req),
        .st_io_blocked (st_io_blocked),
        .rollback      (rollback),
        .starve        (starve_cnt_q == STARVE_LIM),
        .grant         (grant)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mc_req_d     = mc_req_q;
        mc_kind_d    = mc_kind_q;
        mc_addr_d    = mc_addr_q;
        mc_len_d     = mc_len_q;
        mc_wdata_d   = mc_wdata_q;
        if_done_d    = if_done_q;
        ld_done_d    = ld_done_q;
        st_done_d    = st_done_q;
        ld_data_d    = ld_data_q;
        if_data_d    = if_data_q;

        // with rdy low everything, including a pending done pulse, is held
        if (rdy) begin
            if_done_d = 1'b0;
            ld_done_d = 1'b0;
            st_done_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant[KIND_STORE]) begin
                        mc_kind_d  = KIND_STORE;
                        mc_addr_d  = st_addr;
                        mc_len_d   = st_len;
                        mc_wdata_d = st_data;
                    end else if (grant[KIND_LOAD]) begin
                        mc_kind_d  = KIND_LOAD;
                        mc_addr_d  = ld_addr;
                        mc_len_d   = ld_len;
                        mc_wdata_d = '0;
                    end else if (grant[KIND_FETCH]) begin
                        mc_kind_d  = KIND_FETCH;
                        mc_addr_d  = if_pc;
                        mc_len_d   = '0;
                        mc_wdata_d = '0;
                    end
                    if (|grant) begin
                        mc_req_d = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mc_done) begin
                        mc_req_d = 1'b0;
                        state_d  = ST_GAP;
                        if (!squash) begin
                            case (mc_kind_q)
                                KIND_FETCH: begin
                                    if_done_d = 1'b1;
                                    if_data_d = mc_ifdata;
                                end
                                KIND_LOAD: begin
                                    ld_done_d = 1'b1;
                                    ld_data_d = mc_rdata;
                                end
                                default: st_done_d = 1'b1;
                            endcase
                        end
                    end else if (squash) begin
                        // controller is already working; wait for it, drop the result
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mc_done) begin
                        mc_req_d = 1'b0;
                        state_d  = ST_GAP;
                    end
                end
                ST_GAP:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (state_q == ST_IDLE && grant[KIND_FETCH]) begin
                starve_cnt_d = '0;
            end else if (state_q == ST_IDLE && (|grant) && starve_cnt_q != STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            mc_req_q     <= 1'b0;
            mc_kind_q    <= '0;
            mc_addr_q    <= '0;
            mc_len_q     <= '0;
            mc_wdata_q   <= '0;
            if_done_q    <= 1'b0;
            ld_done_q    <= 1'b0;
            st_done_q    <= 1'b0;
            ld_data_q    <= '0;
            if_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mc_req_q     <= mc_req_d;
            mc_kind_q    <= mc_kind_d;
            mc_addr_q    <= mc_addr_d;
            mc_len_q     <= mc_len_d;
            mc_wdata_q   <= mc_wdata_d;
            if_done_q    <= if_done_d;
            ld_done_q    <= ld_done_d;
            st_done_q    <= st_done_d;
            ld_data_q    <= ld_data_d;
            if_data_q    <= if_data_d;
        end
    end

    assign mc_req   = mc_req_q;
    assign mc_kind  = mc_kind_q;
    assign mc_addr  = mc_addr_q;
    assign mc_len   = mc_len_q;
    assign mc_wdata = mc_wdata_q;
    assign if_done  = if_done_q;
    assign ld_done  = ld_done_q;
    assign st_done  = st_done_q;
    assign ld_data  = ld_data_q;
    assign if_data  = if_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios followed by a randomized run. A transaction-level
//   reference model (owner flag, squash flag, cooldown counter, starvation
//   count) predicts every registered output each cycle.
module tb_mem_arbiter;

    localparam int         SMAX    = 4;
    localparam int         IFW     = 128;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    logic           clk = 1'b0;
    logic           rst_n, rdy, rollback, io_buffer_full;
    logic           if_req;  logic [31:0] if_pc;
    logic           if_done; logic [IFW-1:0] if_data;
    logic           ld_req;  logic [31:0] ld_addr; logic [2:0] ld_len;
    logic           ld_done; logic [31:0] ld_data;
    logic           st_req;  logic [31:0] st_addr; logic [2:0] st_len; logic [31:0] st_data;
    logic           st_done;
    logic           mc_req;  logic [1:0] mc_kind; logic [31:0] mc_addr;
    logic [2:0]     mc_len;  logic [31:0] mc_wdata;
    logic           mc_done; logic [31:0] mc_rdata; logic [IFW-1:0] mc_ifdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SMAX), .IF_DATA_W(IFW)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
        .st_done(st_done),
        .mc_req(mc_req), .mc_kind(mc_kind), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
        .mc_ifdata(mc_ifdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic           e_mc_req = 0; logic [1:0] e_kind = 0;
    logic [31:0]    e_addr = 0;   logic [2:0] e_len = 0; logic [31:0] e_wdata = 0;
    logic           e_if_done = 0, e_ld_done = 0, e_st_done = 0;
    logic [31:0]    e_ld_data = 0; logic [IFW-1:0] e_if_data = 0;
    bit             m_squash = 0;
    int             m_cool = 0;
    int             m_starve = 0;

    task automatic model_step();
        int win;
        bit st_ok, ld_ok, if_ok;
        if (!rst_n) begin
            e_mc_req = 0; e_kind = 0; e_addr = 0; e_len = 0; e_wdata = 0;
            e_if_done = 0; e_ld_done = 0; e_st_done = 0; e_ld_data = 0; e_if_data = 0;
            m_squash = 0; m_cool = 0; m_starve = 0;
            return;
        end
        if (!rdy) return;
        e_if_done = 0; e_ld_done = 0; e_st_done = 0;
        win = -1;
        if (e_mc_req) begin
            if (rollback && e_kind != K_STORE) m_squash = 1;
            if (mc_done) begin
                e_mc_req = 0;
                m_cool   = 1;
                if (!m_squash) begin
                    if (e_kind == K_FETCH)     begin e_if_done = 1; e_if_data = mc_ifdata; end
                    else if (e_kind == K_LOAD) begin e_ld_done = 1; e_ld_data = mc_rdata; end
                    else                             e_st_done = 1;
                end
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            st_ok = st_req && !(st_addr[17:16] == 2'b11 && io_buffer_full);
            ld_ok = ld_req && !rollback;
            if_ok = if_req && !rollback;
            if (if_ok && m_starve == SMAX) win = 0;
            else if (st_ok)                win = 2;
            else if (ld_ok)                win = 1;
            else if (if_ok)                win = 0;
            if (win == 0) begin e_kind = K_FETCH; e_addr = if_pc;   e_len = 0;      e_wdata = 0;       end
            if (win == 1) begin e_kind = K_LOAD;  e_addr = ld_addr; e_len = ld_len; e_wdata = 0;       end
            if (win == 2) begin e_kind = K_STORE; e_addr = st_addr; e_len = st_len; e_wdata = st_data; end
            if (win >= 0) begin e_mc_req = 1; m_squash = 0; end
        end
        if (!if_req)                          m_starve = 0;
        else if (win == 0)                    m_starve = 0;
        else if (win > 0 && m_starve < SMAX)  m_starve++;
    endtask

    task automatic compare_all();
        chk("mc_req",   mc_req,   e_mc_req);
        chk("mc_kind",  mc_kind,  e_kind);
        chk("mc_addr",  mc_addr,  e_addr);
        chk("mc_len",   mc_len,   e_len);
        chk("mc_wdata", mc_wdata, e_wdata);
        chk("if_done",  if_done,  e_if_done);
        chk("ld_done",  ld_done,  e_ld_done);
        chk("st_done",  st_done,  e_st_done);
        chk("ld_data",  ld_data,  e_ld_data);
        chk("if_data",  if_data,  e_if_data);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 0; rdy = 1; rollback = 0; io_buffer_full = 0;
        if_req = 0; ld_req = 0; st_req = 0; mc_done = 0;
        cyc();
        rst_n = 1;
    endtask

    // wait for a grant, check it, serve it after lat cycles, check the done pulse
    task automatic grant_serve(input logic [1:0] kind, input logic [31:0] addr,
                               input int lat, output int waited);
        logic [31:0]    rd;
        logic [IFW-1:0] ifd;
        waited = 0;
        while (mc_req !== 1'b1 && waited < 20) begin
            cyc();
            waited++;
        end
        chk("grant_seen", mc_req, 1'b1);
        chk("grant_kind", mc_kind, kind);
        chk("grant_addr", mc_addr, addr);
        repeat (lat) cyc();
        rd  = $urandom;
        ifd = {$urandom, $urandom, $urandom, $urandom};
        mc_done = 1; mc_rdata = rd; mc_ifdata = ifd;
        cyc();
        mc_done = 0;
        chk("done_onehot", {if_done, ld_done, st_done},
            (kind == K_FETCH) ? 3'b100 : (kind == K_LOAD) ? 3'b010 : 3'b001);
        if (kind == K_FETCH) begin chk("if_data_x", if_data, ifd); if_req = 0; end
        if (kind == K_LOAD)  begin chk("ld_data_x", ld_data, rd);  ld_req = 0; end
        if (kind == K_STORE) st_req = 0;
        cyc();
        chk("done_width", {if_done, ld_done, st_done}, 3'b000);
        chk("gap_no_req", mc_req, 1'b0);
    endtask

    initial begin
        int w;
        bit ctl_wait_low;
        int ctl_lat;

        rst_n = 0; rdy = 1; rollback = 0; io_buffer_full = 0;
        if_req = 0; if_pc = 0; ld_req = 0; ld_addr = 0; ld_len = 0;
        st_req = 0; st_addr = 0; st_len = 0; st_data = 0;
        mc_done = 0; mc_rdata = 0; mc_ifdata = 0;

        // reset state
        cyc(); cyc();
        chk("rst_mc_req", mc_req, 1'b0);
        chk("rst_dones", {if_done, ld_done, st_done}, 3'b000);
        chk("rst_mc_addr", mc_addr, 32'h0);
        chk("rst_if_data", if_data, 128'h0);
        rst_n = 1;

        // simultaneous requests: STORE, LOAD, FETCH
        if_req = 1; if_pc = 32'h0000_1000;
        ld_req = 1; ld_addr = 32'h0000_0200; ld_len = 3'd2;
        st_req = 1; st_addr = 32'h0000_0100; st_len = 3'd4; st_data = 32'hDEAD_BEEF;
        grant_serve(K_STORE, 32'h100, 2, w);  chk("lat_store", w, 1);
        chk("store_wdata", mc_wdata, 32'hDEAD_BEEF);
        grant_serve(K_LOAD,  32'h200, 1, w);  chk("lat_load_d3", w, 1);
        grant_serve(K_FETCH, 32'h1000, 3, w); chk("lat_fetch_d3", w, 1);

        // starvation: four loads then the waiting fetch
        do_reset();
        if_req = 1; if_pc = 32'h0000_4000;
        for (int k = 0; k < 4; k++) begin
            ld_req = 1; ld_addr = 32'h1000 + 32'(k * 4);
            grant_serve(K_LOAD, 32'h1000 + 32'(k * 4), 1, w);
        end
        ld_req = 1; ld_addr = 32'h2000;
        grant_serve(K_FETCH, 32'h4000, 1, w);
        grant_serve(K_LOAD, 32'h2000, 1, w);

        // I/O store blocked while the UART buffer is full
        do_reset();
        io_buffer_full = 1;
        st_req = 1; st_addr = 32'h0003_0000; st_len = 3'd1; st_data = 32'h55;
        ld_req = 1; ld_addr = 32'h0000_2000; ld_len = 3'd4;
        grant_serve(K_LOAD, 32'h2000, 2, w);
        chk("io_store_held", st_done, 1'b0);
        io_buffer_full = 0;
        grant_serve(K_STORE, 32'h0003_0000, 1, w); chk("io_store_next_idle", w, 1);

        // rollback two cycles after a LOAD grant: drain, no ld_done
        do_reset();
        ld_req = 1; ld_addr = 32'h3000; ld_len = 3'd4;
        cyc(); chk("rb_ld_grant", mc_req, 1'b1);
        cyc();
        rollback = 1; ld_req = 0;
        cyc();
        rollback = 0;
        repeat (3) begin
            cyc();
            chk("drain_hold_req", mc_req, 1'b1);
            chk("drain_no_ld_done", ld_done, 1'b0);
        end
        mc_done = 1; mc_rdata = 32'hBAD0_BAD0;
        cyc();
        mc_done = 0;
        chk("drain_req_drop", mc_req, 1'b0);
        chk("drain_no_done", ld_done, 1'b0);
        chk("drain_data_kept", ld_data, 32'h0);
        cyc();
        ld_req = 1; ld_addr = 32'h3004;
        grant_serve(K_LOAD, 32'h3004, 1, w); chk("drain_gap_idle", w, 1);

        // rollback during a STORE, then rollback coincident with FETCH done
        do_reset();
        st_req = 1; st_addr = 32'h500; st_len = 3'd2; st_data = 32'h1234;
        cyc();
        rollback = 1;
        cyc();
        rollback = 0;
        chk("st_rb_busy", mc_req, 1'b1);
        mc_done = 1;
        cyc();
        mc_done = 0; st_req = 0;
        chk("st_done_rb", st_done, 1'b1);
        cyc(); cyc();
        if_req = 1; if_pc = 32'h6000;
        cyc(); chk("if_rb_kind", mc_kind, K_FETCH);
        cyc();
        mc_done = 1; rollback = 1;
        cyc();
        mc_done = 0; rollback = 0; if_req = 0;
        chk("if_rb_no_done", if_done, 1'b0);
        chk("if_rb_req_drop", mc_req, 1'b0);
        repeat (3) begin cyc(); chk("if_rb_never", if_done, 1'b0); end

        // rdy low freezes BUSY, then deferred done pulse
        do_reset();
        ld_req = 1; ld_addr = 32'h7000; ld_len = 3'd4;
        cyc();
        rdy = 0; mc_done = 1;
        repeat (3) begin
            cyc();
            chk("rdy_hold_req", mc_req, 1'b1);
            chk("rdy_hold_addr", mc_addr, 32'h7000);
            chk("rdy_no_done", ld_done, 1'b0);
        end
        rdy = 1; mc_done = 0;
        cyc(); chk("rdy_resume_busy", mc_req, 1'b1);
        mc_done = 1; mc_rdata = 32'hCAFE_F00D;
        cyc();
        mc_done = 0; rdy = 0;
        chk("rdy_done", ld_done, 1'b1);
        cyc();
        chk("rdy_done_deferred", ld_done, 1'b1);
        rdy = 1; ld_req = 0;
        cyc();
        chk("rdy_done_clear", ld_done, 1'b0);
        chk("rdy_ld_data", ld_data, 32'hCAFE_F00D);

        // reset mid-BUSY
        do_reset();
        ld_req = 1; ld_addr = 32'h7100; ld_len = 3'd3;
        cyc(); chk("rst_mid_grant", mc_req, 1'b1);
        rst_n = 0;
        cyc();
        chk("rst_mid_req", mc_req, 1'b0);
        chk("rst_mid_addr", mc_addr, 32'h0);
        chk("rst_mid_len", mc_len, 3'd0);
        rst_n = 1; ld_req = 0;
        cyc(); chk("rst_mid_no_done", ld_done, 1'b0);

        // randomized traffic
        do_reset();
        ctl_wait_low = 0;
        ctl_lat = 1;
        for (int c = 0; c < 4000; c++) begin
            rst_n          = ($urandom_range(0, 499) != 0);
            rdy            = ($urandom_range(0, 9) != 0);
            rollback       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) io_buffer_full = ~io_buffer_full;

            if (if_done) if_req = 0;
            else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_pc = $urandom;
            end
            if (ld_done) ld_req = 0;
            else if (!ld_req && $urandom_range(0, 3) == 0) begin
                ld_req = 1; ld_addr = $urandom; ld_len = 3'($urandom);
            end
            if (st_done) st_req = 0;
            else if (!st_req && $urandom_range(0, 3) == 0) begin
                st_req = 1; st_addr = $urandom; st_len = 3'($urandom); st_data = $urandom;
                if ($urandom_range(0, 1) == 1) st_addr[17:16] = 2'b11;
            end
            if (rollback && $urandom_range(0, 1) == 1) if_req = 0;
            if (rollback && $urandom_range(0, 1) == 1) ld_req = 0;

            mc_done = 0;
            if (!rst_n) begin
                ctl_wait_low = 0;
                ctl_lat = $urandom_range(0, 4);
            end else if (ctl_wait_low) begin
                if (!mc_req) ctl_wait_low = 0;
            end else if (mc_req && rdy) begin
                if (ctl_lat == 0) begin
                    mc_done = 1; mc_rdata = $urandom;
                    mc_ifdata = {$urandom, $urandom, $urandom, $urandom};
                    ctl_wait_low = 1;
                    ctl_lat = $urandom_range(0, 4);
                end else begin
                    ctl_lat--;
                end
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
